// File: rtl/dvs_ravens_pkg.sv
// Shared DVS/RAVENS definitions: packed event layout, replay FSM states and
// the microsecond-to-cycle conversion used by the event replayer.
package dvs_ravens_pkg;

  localparam int DVS_X_ADDR_BITS          = 9;
  localparam int DVS_Y_ADDR_BITS          = 9;
  localparam int TIMESTAMP_US_BITS        = 48;
  localparam int EVENT_BITS               = 67;
  localparam int TIMESTAMP_CLK_CYCLE_BITS = 55;
  localparam int CLK_PERIOD_US_DIVISOR    = 100;

  typedef struct packed {
    logic [DVS_X_ADDR_BITS-1:0]   x;
    logic [DVS_Y_ADDR_BITS-1:0]   y;
    logic                         polarity;
    logic [TIMESTAMP_US_BITS-1:0] timestamp_us;
  } dvs_event_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EMIT
  } replay_state_t;

  // x100 as 64x + 32x + 4x so no hard multiplier is inferred
  function automatic logic [TIMESTAMP_CLK_CYCLE_BITS-1:0] us_to_cycles(
    input logic [TIMESTAMP_US_BITS-1:0] d
  );
    logic [TIMESTAMP_CLK_CYCLE_BITS-1:0] e;
    e = {{(TIMESTAMP_CLK_CYCLE_BITS-TIMESTAMP_US_BITS){1'b0}}, d};
    return (e << 6) + (e << 5) + (e << 2);
  endfunction

endpackage

// File: rtl/dvs_event_replay_timer.sv
// Replay time base: counts clock cycles since the first accepted event,
// saturating at all-ones so very long sessions never wrap.
module dvs_cycle_timer
  import dvs_ravens_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                restart,
  input  logic                                first_accept,
  output logic                                started,
  output logic [TIMESTAMP_CLK_CYCLE_BITS-1:0] cycle_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started   <= 1'b0;
      cycle_cnt <= '0;
    end else if (restart) begin
      started   <= 1'b0;
      cycle_cnt <= '0;
    end else if (first_accept) begin
      started   <= 1'b1;
      cycle_cnt <= '0;
    end else if (started && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dvs_event_replay.sv
// Unpacks DVS events and releases each one at the cycle matching its
// timestamp offset from the first event, flagging releases that slipped.
module dvs_event_replay
  import dvs_ravens_pkg::*;
#(
  parameter int unsigned LATE_TOL_CYCLES = CLK_PERIOD_US_DIVISOR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         restart,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [EVENT_BITS-1:0]        in_event,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DVS_X_ADDR_BITS-1:0]   out_x,
  output logic [DVS_Y_ADDR_BITS-1:0]   out_y,
  output logic                         out_polarity,
  output logic [TIMESTAMP_US_BITS-1:0] out_timestamp_us,
  output logic                         out_late
);

  localparam logic [TIMESTAMP_CLK_CYCLE_BITS-1:0] LATE_TOL =
    TIMESTAMP_CLK_CYCLE_BITS'(LATE_TOL_CYCLES);

  replay_state_t                       state_reg;
  logic                                in_ready_reg;
  logic [TIMESTAMP_US_BITS-1:0]        base_ts_reg;
  logic [TIMESTAMP_CLK_CYCLE_BITS-1:0] target_reg;
  logic                                nonmono_reg;

  dvs_event_t                          ev;
  logic                                accept;
  logic                                started;
  logic [TIMESTAMP_CLK_CYCLE_BITS-1:0] cycle_cnt;
  logic                                nonmono;
  logic [TIMESTAMP_US_BITS-1:0]        delta;
  logic [TIMESTAMP_CLK_CYCLE_BITS-1:0] target_next;
  logic [TIMESTAMP_CLK_CYCLE_BITS-1:0] slack;
  logic                                late_next;

  assign ev       = dvs_event_t'(in_event);
  // restart beats a coincident handshake, so gate the ready combinationally
  assign in_ready = in_ready_reg & ~restart;
  assign accept   = in_valid & in_ready;

  // the first event after reset/restart is its own base: zero offset
  assign nonmono     = started && (ev.timestamp_us < base_ts_reg);
  assign delta       = started ? (ev.timestamp_us - base_ts_reg) : '0;
  assign target_next = nonmono ? '0 : us_to_cycles(delta);
  assign slack       = cycle_cnt - target_reg;
  assign late_next   = nonmono_reg | (slack > LATE_TOL);

  dvs_cycle_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .restart      (restart),
    .first_accept (accept & ~started),
    .started      (started),
    .cycle_cnt    (cycle_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      in_ready_reg     <= 1'b1;
      out_valid        <= 1'b0;
      out_late         <= 1'b0;
      out_x            <= '0;
      out_y            <= '0;
      out_polarity     <= 1'b0;
      out_timestamp_us <= '0;
      base_ts_reg      <= '0;
      target_reg       <= '0;
      nonmono_reg      <= 1'b0;
    end else if (restart) begin
      state_reg    <= IDLE;
      in_ready_reg <= 1'b1;
      out_valid    <= 1'b0;
      out_late     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            out_x            <= ev.x;
            out_y            <= ev.y;
            out_polarity     <= ev.polarity;
            out_timestamp_us <= ev.timestamp_us;
            target_reg       <= target_next;
            nonmono_reg      <= nonmono;
            if (!started) base_ts_reg <= ev.timestamp_us;
            in_ready_reg     <= 1'b0;
            state_reg        <= WAIT;
          end
        end
        WAIT: begin
          if (cycle_cnt >= target_reg) begin
            out_late  <= late_next;
            out_valid <= 1'b1;
            state_reg <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            out_late     <= 1'b0;
            in_ready_reg <= 1'b1;
            state_reg    <= IDLE;
          end
        end
        default: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b1;
          out_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dvs_event_replay.sv
// Directed bench for dvs_event_replay: timing of releases against a small
// cycle model, lateness flags, restart and asynchronous reset behaviour.
module tb_dvs_event_replay;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [66:0] in_event = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [8:0]  out_x;
  logic [8:0]  out_y;
  logic        out_polarity;
  logic [47:0] out_timestamp_us;
  logic        out_late;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference time base
  bit     m_started = 0;
  longint m_base_ts = 0;
  int     m_base_cyc = 0;

  dvs_event_replay dut (
    .clk              (clk),
    .rst              (rst),
    .restart          (restart),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_event         (in_event),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_x            (out_x),
    .out_y            (out_y),
    .out_polarity     (out_polarity),
    .out_timestamp_us (out_timestamp_us),
    .out_late         (out_late)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // offer an event at the current negedge, return the accept cycle
  task automatic send(input logic [8:0] x, input logic [8:0] y, input logic p,
                      input longint ts, output int acc);
    int n = 0;
    in_event = {x, y, p, ts[47:0]};
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int t);
    int n = 0;
    while (!out_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("valid_timeout", {63'd0, out_valid}, 64'd1);
    t = cyc;
  endtask

  // model: expected release cycle and late flag of an event accepted at acc
  task automatic model(input longint ts, input int acc, output int rel, output bit late);
    longint tgt;
    longint cnt;
    bit     nm;
    int     t;
    if (!m_started) begin
      m_started  = 1;
      m_base_ts  = ts;
      m_base_cyc = acc;
    end
    nm  = ts < m_base_ts;
    tgt = nm ? 0 : (ts - m_base_ts) * 100;
    t   = acc + 1;
    if (longint'(m_base_cyc) + 1 + tgt > longint'(t)) t = m_base_cyc + 1 + int'(tgt);
    cnt  = t - m_base_cyc - 1;
    rel  = t + 1;
    late = nm || ((cnt - tgt) > 100);
  endtask

  task automatic check_event(input string tag, input logic [8:0] x, input logic [8:0] y,
                             input logic p, input longint ts, input int rel, input bit late);
    int t;
    wait_valid(t);
    chk({tag, "_cycle"}, t, rel);
    chk({tag, "_x"}, out_x, x);
    chk({tag, "_y"}, out_y, y);
    chk({tag, "_pol"}, out_polarity, p);
    chk({tag, "_ts"}, out_timestamp_us, ts);
    chk({tag, "_late"}, out_late, late);
  endtask

  initial begin
    int acc, rel, t, n;
    bit late, stable;
    logic [66:0] held;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_late", out_late, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_ts", out_timestamp_us, 0);

    // first event: zero target, released at accept+2
    send(9'd10, 9'd20, 1'b1, 1000, acc);
    model(1000, acc, rel, late);
    chk("a_n1_valid", out_valid, 0);
    chk("a_n1_ready", in_ready, 0);
    check_event("a", 9'd10, 9'd20, 1'b1, 1000, acc + 2, 0);
    chk("a_model_rel", rel, acc + 2);
    @(negedge clk);
    chk("a_post_valid", out_valid, 0);
    chk("a_post_ready", in_ready, 1);

    // second event 5 us later: target 500 cycles
    send(9'd1, 9'd2, 1'b0, 1005, acc);
    model(1005, acc, rel, late);
    check_event("b", 9'd1, 9'd2, 1'b0, 1005, m_base_cyc + 502, 0);
    @(negedge clk);

    // non-monotonic timestamp
    send(9'd300, 9'd400, 1'b1, 990, acc);
    model(990, acc, rel, late);
    check_event("c", 9'd300, 9'd400, 1'b1, 990, acc + 2, 1);
    @(negedge clk);

    // back-pressure for 300 cycles
    out_ready = 1'b0;
    send(9'd7, 9'd8, 1'b0, 1005, acc);
    model(1005, acc, rel, late);
    check_event("d", 9'd7, 9'd8, 1'b0, 1005, rel, late);
    held   = {out_x, out_y, out_polarity, out_timestamp_us};
    stable = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!out_valid || ({out_x, out_y, out_polarity, out_timestamp_us} !== held)) stable = 0;
    end
    chk("d_hold_stable", stable, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("d_released", out_valid, 0);
    send(9'd9, 9'd11, 1'b1, 1006, acc);
    model(1006, acc, rel, late);
    check_event("e", 9'd9, 9'd11, 1'b1, 1006, acc + 2, 1);
    chk("e_model_late", late, 1);
    @(negedge clk);

    // restart during WAIT discards the held event
    send(9'd5, 9'd5, 1'b1, 100000, acc);
    chk("f_in_wait", out_valid, 0);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    m_started = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("f_never_valid", n, 0);
    chk("f_ready_after", in_ready, 1);

    send(9'd33, 9'd44, 1'b0, 5000, acc);
    model(5000, acc, rel, late);
    check_event("g", 9'd33, 9'd44, 1'b0, 5000, acc + 2, 0);
    @(negedge clk);
    send(9'd34, 9'd45, 1'b1, 5001, acc);
    model(5001, acc, rel, late);
    check_event("h", 9'd34, 9'd45, 1'b1, 5001, m_base_cyc + 102, late);
    chk("h_model_rel", rel, m_base_cyc + 102);
    @(negedge clk);

    // restart coincident with an offered event: not accepted
    in_event = {9'd1, 9'd1, 1'b1, 48'd7000};
    in_valid = 1'b1;
    restart  = 1'b1;
    #1;
    chk("rs_in_ready", in_ready, 0);
    @(negedge clk);
    restart  = 1'b0;
    in_valid = 1'b0;
    m_started = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("rs_not_taken", n, 0);

    // reset while EMIT is held by back-pressure
    out_ready = 1'b0;
    send(9'd2, 9'd3, 1'b0, 8000, acc);
    model(8000, acc, rel, late);
    wait_valid(t);
    chk("r_valid_before", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("r_async_valid", out_valid, 0);
    chk("r_async_late", out_late, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    m_started = 0;
    chk("r_in_ready", in_ready, 1);
    send(9'd4, 9'd6, 1'b1, 50, acc);
    model(50, acc, rel, late);
    check_event("i", 9'd4, 9'd6, 1'b1, 50, acc + 2, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dvs_event_replay.md
# dvs_event_replay

Consumes packed DVS events in the shared `dvs_ravens_pkg` format and unpacks them into x address, y address, polarity and timestamp. Releases each event downstream at the clock cycle that matches its microsecond timestamp relative to the first event, so the RAVENS side sees spikes with camera-accurate spacing. Sits between the event FIFO/host loader and the RAVENS spike-injection logic.

## Interface
Parameters:
- `LATE_TOL_CYCLES`, default `CLK_PERIOD_US_DIVISOR` (100). Release slack, in cycles, beyond which an event is flagged late.

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  reset, asynchronous, active-high
- `restart`  in  1  synchronous pulse: abandon current event, clear time base
- `in_valid`  in  1  packed event available
- `in_ready`  out  1  block can accept an event
- `in_event`  in  `EVENT_BITS` (67)  packed as {x[66:58], y[57:49], polarity[48], timestamp_us[47:0]}
- `out_valid`  out  1  unpacked event presented
- `out_ready`  in  1  downstream accepts
- `out_x`  out  `DVS_X_ADDR_BITS` (9)  event x address
- `out_y`  out  `DVS_Y_ADDR_BITS` (9)  event y address
- `out_polarity`  out  1  event polarity
- `out_timestamp_us`  out  48  original timestamp
- `out_late`  out  1  qualifies `out_valid`: release missed deadline

## Operation
- FSM states: IDLE, WAIT, EMIT.
  - IDLE: `in_ready`=1. On `in_valid & in_ready`, register fields and target, then go to WAIT.
  - WAIT: when `cycle_cnt >= target`, go to EMIT and register `out_late`.
  - EMIT: `out_valid`=1, outputs held stable until `out_ready`, then return to IDLE. `in_ready`=0 in WAIT and EMIT.
- Time base:
  - The first event accepted after reset or `restart` sets `base_ts` to its timestamp and sets `started`.
  - `cycle_cnt` (`TIMESTAMP_CLK_CYCLE_BITS` = 55 bits) clears to 0 in that same accept cycle. It then increments every cycle and saturates at all-ones.
- Target: `target = (ts - base_ts) * 100` in 55 bits. Implement the multiply as shift-add `(d<<6)+(d<<5)+(d<<2)`; no DSP multiplier.
- Non-monotonic timestamp (`ts < base_ts`): target = 0 and `out_late` = 1.
- Late rule: `out_late` = 1 if `cycle_cnt - target > LATE_TOL_CYCLES` on the WAIT→EMIT cycle, or if the timestamp is non-monotonic.
- `restart`:
  - Next state is IDLE, `out_valid` drops next cycle, `started` and `cycle_cnt` clear.
  - Any held event is discarded.
  - `restart` coincident with an input handshake: `restart` wins and the input is not accepted (`in_ready` forced 0 that cycle).
- Reset values: state IDLE, `in_ready`=1 after reset release, `out_valid`=0, `out_late`=0, all data outputs 0, `cycle_cnt`=0, `started`=0.

## Timing
- Accept in cycle N. WAIT is entered at N+1. Earliest `out_valid` is N+2 (zero target).
- Nonzero target: `out_valid` rises the cycle after the first cycle where `cycle_cnt >= target`.
- After the `out_ready` handshake in cycle M: `in_ready`=1 at M+1. Throughput is at most one event per 3 cycles.
- `out_valid` never deasserts without `out_ready` (except reset/`restart`). Data outputs are stable while `out_valid` is high.
- `cycle_cnt` keeps running through EMIT back-pressure. Back-pressure delay shows up as lateness on following events.

## Structure
- Add to `dvs_ravens_pkg`:
  - `dvs_event_t` packed struct (x, y, polarity, timestamp_us) matching the bit order above.
  - `replay_state_t` enum {IDLE, WAIT, EMIT}.
- One sub-module: `dvs_cycle_timer`. It holds `started`, the saturating 55-bit `cycle_cnt`, its clear on first-accept/`restart`, and outputs `cycle_cnt`.
- Target shift-add and comparison stay in the top module.

## Test plan
- Reset mid-EMIT (`rst` pulse while `out_valid`=1) → `out_valid`=0 immediately (async). `in_ready`=1 after release. Next event treated as first.
- First event x=10, y=20, p=1, ts=1000, accepted cycle N → `out_valid` at N+2, `out_x`=10, `out_y`=20, `out_polarity`=1, `out_timestamp_us`=1000, `out_late`=0.
- Second event ts=1005, offered immediately after first handshake → released one cycle after `cycle_cnt` reaches 500 (±0). `out_late`=0.
- Event ts=990 after base 1000 → released at accept+2 with `out_late`=1.
- Hold `out_ready`=0 for 300 cycles on event ts=1005, then send ts=1006 (target 600) → second released as soon as WAIT is reached with `out_late`=1, since `cycle_cnt - 600 > 100`.
- `restart` asserted during WAIT → `out_valid` never rises for held event. Next event ts=5000 becomes the new base and is released at accept+2.
